eda_push_queue: RTL
===================

// Module: eda_push_queue
// PURPOSE
//  Consumer side of the regional-max compare stage: takes the 8-bit neighbour push mask
//  plus the centre pixel address and serialises every set bit into a neighbour pixel address.
//  Each address is written into an internal FIFO; the flood-fill window fetcher drains it.
//  The fetcher pops over a valid/ready interface.
// PARAMETERS
//  M             16               image rows
//  N             16               image columns
//  WINDOW_WIDTH  9                3x3 window size; mask width is WINDOW_WIDTH-1
//  ADDR_WIDTH    $clog2(M*N)      row-major pixel address width (addr = i*N + j)
//  DEPTH         16               FIFO entries, power of two, >= 2
//  CNT_WIDTH     $clog2(DEPTH)+1  occupancy counter width
// PORTS
//  clk             in   1                clock
//  reset           in   1                asynchronous reset, active-high
//  flush           in   1                synchronous clear of FIFO, serializer and overflow
//  push_valid      in   1                push_positions/center_addr valid
//  push_ready      out  1                serializer idle, can accept a new mask
//  push_positions  in   WINDOW_WIDTH-1   neighbour mask (bit k = neighbour k)
//  center_addr     in   ADDR_WIDTH       address of window centre pixel
//  pop_valid       out  1                FIFO non-empty, pop_addr valid
//  pop_ready       in   1                consumer takes pop_addr
//  pop_addr        out  ADDR_WIDTH       head-of-FIFO neighbour address
//  fifo_count      out  CNT_WIDTH        current occupancy
//  full            out  1                fifo_count == DEPTH
//  empty           out  1                fifo_count == 0
//  overflow        out  1                sticky: push_valid seen while push_ready=0
// BEHAVIOUR
//  - Interface: one clock, reset is asynchronous and active-high.
//  - Reset values: push_ready=1, pop_valid=0, pop_addr=0, fifo_count=0, full=0, empty=1, overflow=0.
//    The serializer state is IDLE.
//  - Neighbour offsets (dr,dc) by mask bit:
//    0:(-1,-1) 1:(-1,0) 2:(-1,+1) 3:(0,-1) 4:(0,+1) 5:(+1,-1) 6:(+1,0) 7:(+1,+1).
//  - Neighbour address = center_addr + dr*N + dc, computed modulo 2^ADDR_WIDTH.
//    There is no bounds check: the upstream stage has already masked invalid neighbours.
//  - FSM IDLE: push_ready=1. A handshake (push_valid & push_ready) latches mask and centre.
//    A non-zero mask moves the FSM to SER. A zero mask is consumed with no state change.
//  - FSM SER: push_ready=0. Each cycle the FSM picks the lowest set bit of the latched mask.
//    If full=0 at the start of the cycle: write the address and clear that bit.
//    If full=1: hold with no write and the mask unchanged.
//    The FSM returns to IDLE on the cycle its last bit is written; push_ready=1 the next cycle.
//  - Latency: first FIFO write occurs 1 cycle after the push handshake.
//    A write becomes visible on pop_valid/pop_addr the cycle after the write.
//  - Throughput: 1 address/cycle. Back-to-back masks add 1 IDLE cycle each.
//  - Pop: a transfer happens when pop_valid & pop_ready. pop_addr is the registered head entry.
//    pop_addr is held stable while pop_valid=1 and pop_ready=0.
//  - Write and pop in the same cycle: allowed when not full and not empty; fifo_count is unchanged.
//  - When full: a same-cycle pop does not enable a write. The write waits one cycle.
//  - When empty: pop_ready is ignored and pop_valid=0.
//  - Pointers wrap modulo DEPTH. fifo_count saturates by construction and never exceeds DEPTH.
//  - overflow: set when push_valid=1 and push_ready=0. The offending request is dropped.
//    overflow is cleared only by reset or flush.
//  - flush has priority over push and pop in the same cycle. It empties the FIFO,
//    clears overflow and forces IDLE; outputs take their reset values on the next cycle.
//  - Reset mid-serialization: the remaining mask bits and all queued entries are discarded.
// STRUCTURE
//  - Shared package eda_pkg: neighbour dr/dc constant tables, the serializer state enum
//    (IDLE, SER), and the lowest-set-bit priority function.
//  - One sub-module: eda_sync_fifo #(WIDTH=ADDR_WIDTH, DEPTH). It provides registered head,
//    count/full/empty and the flush input.
//  - The top level holds the FSM, mask register, address adder and overflow flag.
// TESTING  (M=N=16 unless stated)
//  - center=17, mask=8'hFF, pop_ready=1 -> pops 0,1,2,16,18,32,33,34 in order.
//    push_ready=0 for 8 cycles, then 1.
//  - DEPTH=4, center=17, mask=8'hFF, pop_ready=0 -> full=1 after 4 writes and the FSM stalls.
//    Then raise pop_ready -> all 8 addresses are delivered in order with no loss.
//  - mask=8'h00 on push handshake -> push_ready stays 1, fifo_count stays 0, no pop_valid.
//  - Push handshake, then push_valid again 1 cycle later (push_ready=0) -> overflow=1.
//    The second request is dropped; flush -> overflow=0, empty=1.
//  - center=34, mask=8'h18; flush asserted on the first SER cycle -> no entries remain,
//    push_ready=1 next cycle.
//  - Steady write+pop at fifo_count=2 -> count holds at 2.
//    Assert reset mid-SER -> all outputs at reset values immediately.

Source files
------------

// File: rtl/eda_pkg.sv
// Shared definitions for the regional-max push queue: neighbour offset tables,
// serializer state encoding and the lowest-set-bit picker.
package eda_pkg;

    localparam int NBR_COUNT = 8;
    localparam int NBR_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SER  = 1'b1
    } ser_state_t;

    // Row/column offsets of the eight neighbours, indexed by mask bit.
    localparam int NBR_DR [NBR_COUNT] = '{-1, -1, -1,  0,  0,  1,  1,  1};
    localparam int NBR_DC [NBR_COUNT] = '{-1,  0,  1, -1,  1, -1,  0,  1};

    function automatic logic [NBR_IDX_W-1:0] lowest_set_bit(input logic [NBR_COUNT-1:0] mask);
        logic [NBR_IDX_W-1:0] idx;
        idx = '0;
        for (int k = NBR_COUNT - 1; k >= 0; k--) begin
            if (mask[k]) idx = NBR_IDX_W'(k);
        end
        return idx;
    endfunction

    function automatic int nbr_offset(input logic [NBR_IDX_W-1:0] idx, input int n_cols);
        return NBR_DR[idx] * n_cols + NBR_DC[idx];
    endfunction

endpackage

// File: rtl/eda_push_queue_if.sv
// Push (mask + centre) and pop (neighbour address) handshakes of the push queue.
interface eda_push_queue_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int MASK_WIDTH = 8
);
    logic                  push_valid;
    logic                  push_ready;
    logic [MASK_WIDTH-1:0] push_positions;
    logic [ADDR_WIDTH-1:0] center_addr;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [ADDR_WIDTH-1:0] pop_addr;

    modport master (
        output push_valid, push_positions, center_addr, pop_ready,
        input  push_ready, pop_valid, pop_addr
    );

    modport slave (
        input  push_valid, push_positions, center_addr, pop_ready,
        output push_ready, pop_valid, pop_addr
    );
endinterface

// File: rtl/eda_sync_fifo.sv
// Synchronous FIFO with a registered head entry, occupancy count and synchronous flush.
module eda_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_wr, do_rd;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_en & ~empty;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign head       = head_reg;
    assign count      = count_reg;

    // The head follows the write data when the new entry lands directly in the head slot.
    always_comb begin
        head_next = head_reg;
        if (do_wr && (empty || (do_rd && count_reg == CNT_W'(1))))
            head_next = wr_data;
        else if (do_rd && count_reg > CNT_W'(1))
            head_next = mem[rd_ptr_inc];
    end

    always_comb begin
        count_next = count_reg;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end
endmodule

// File: rtl/eda_push_queue.sv
// Serialises a neighbour push mask into neighbour pixel addresses and queues them
// for the flood-fill window fetcher.
module eda_push_queue
    import eda_pkg::*;
#(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M * N),
    parameter int DEPTH        = 16,
    parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    eda_push_queue_if.slave      q,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);
    localparam int MASK_W = WINDOW_WIDTH - 1;

    ser_state_t            state_reg, state_next;
    logic [MASK_W-1:0]     mask_reg, mask_next;
    logic [ADDR_WIDTH-1:0] center_reg, center_next;
    logic                  overflow_reg;
    logic                  push_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_data;
    logic [NBR_IDX_W-1:0]  bit_idx;

    assign bit_idx = lowest_set_bit(mask_reg);
    // Two's-complement truncation gives the required modulo-2^ADDR_WIDTH wrap.
    assign wr_data = ADDR_WIDTH'(32'(center_reg) + 32'(nbr_offset(bit_idx, N)));

    always_comb begin
        state_next  = state_reg;
        mask_next   = mask_reg;
        center_next = center_reg;
        push_ready  = 1'b0;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                push_ready = 1'b1;
                if (q.push_valid) begin
                    mask_next   = q.push_positions;
                    center_next = q.center_addr;
                    if (|q.push_positions) state_next = SER;
                end
            end
            SER: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    mask_next = mask_reg & ~(MASK_W'(1) << bit_idx);
                    if (mask_next == '0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            mask_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            center_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mask_reg    <= mask_next;
            center_reg  <= center_next;
            if (flush)
                overflow_reg <= 1'b0;
            else if (q.push_valid && !push_ready)
                overflow_reg <= 1'b1;
        end
    end

    logic fifo_empty;

    eda_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (q.pop_ready),
        .head    (q.pop_addr),
        .count   (fifo_count),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign empty        = fifo_empty;
    assign q.pop_valid  = ~fifo_empty;
    assign q.push_ready = push_ready;
    assign overflow     = overflow_reg;
endmodule
